// File: rtl/adv_ddr_capture.sv
// adv_ddr_capture: rebuilds 24-bpp RGB from a 12-bit DDR half-pixel stream and measures frame timing.
// Latency: 2 clk from the second half-word at the inputs to o_pix_valid; syncs are delayed to match.
// Backpressure: none; free-running receive path, every input word is consumed on the clk it arrives.
module adv_ddr_capture #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_de,
  input  logic             i_hsync,
  input  logic             i_vsync,
  input  logic [11:0]      i_data,
  output logic [7:0]       o_r,
  output logic [7:0]       o_g,
  output logic [7:0]       o_b,
  output logic             o_pix_valid,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [CNT_W-1:0] o_h_total,
  output logic [CNT_W-1:0] o_h_active,
  output logic [CNT_W-1:0] o_v_total,
  output logic [CNT_W-1:0] o_v_active,
  output logic             o_locked,
  output logic             o_err_phase
);

  // Word counters carry one extra bit: a line of 2*(2^CNT_W-1) words still
  // yields a pixel count that fits CNT_W after the divide-by-two, and a longer
  // line pins the pixel count at its maximum instead of wrapping.
  localparam int                WORD_W     = CNT_W + 1;
  localparam logic [WORD_W-1:0] WORD_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [3:0]        STABLE_MAX = 4'd15;
  localparam logic [3:0]        LOCK_THR   = 4'(LOCK_FRAMES);

  typedef enum logic {
    HALF_A = 1'b0,
    HALF_B = 1'b1
  } phase_t;

  // Stage-1 copies of the inputs and one extra sync tap for edge detection
  logic        de_s1;
  logic        hsync_s1;
  logic        vsync_s1;
  logic [11:0] data_s1;
  logic        hsync_s1_q;
  logic        vsync_s1_q;
  logic        hs_rise;
  logic        vs_rise;

  // Pixel assembly
  phase_t      state;
  phase_t      state_nxt;
  logic        latch_en;
  logic        pix_en;
  logic        err_now;
  logic [11:0] half_word;

  // Line measurement
  logic [WORD_W-1:0] word_cnt;
  logic [WORD_W-1:0] de_cnt;
  logic [CNT_W-1:0]  h_line;
  logic [CNT_W-1:0]  h_act_line;
  logic [CNT_W-1:0]  v_cnt;
  logic [CNT_W-1:0]  v_act_cnt;
  logic [CNT_W-1:0]  h_line_nxt;
  logic [CNT_W-1:0]  h_act_nxt;
  logic [CNT_W-1:0]  v_cnt_nxt;
  logic [CNT_W-1:0]  v_act_nxt;
  logic [CNT_W-1:0]  de_pix;

  // Frame publication and lock
  logic [1:0] pub_seen;
  logic [3:0] stable;
  logic [3:0] stable_nxt;
  logic       err_seen;
  logic       frame_err;
  logic       tuple_match;

  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [WORD_W-1:0] inc_word(input logic [WORD_W-1:0] v);
    return (v == WORD_MAX) ? v : v + 1'b1;
  endfunction

  // Retime all inputs onto stage 1; keep the previous sync levels for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_s1      <= 1'b0;
      hsync_s1   <= 1'b0;
      vsync_s1   <= 1'b0;
      data_s1    <= '0;
      hsync_s1_q <= 1'b0;
      vsync_s1_q <= 1'b0;
    end else begin
      de_s1      <= i_de;
      hsync_s1   <= i_hsync;
      vsync_s1   <= i_vsync;
      data_s1    <= i_data;
      hsync_s1_q <= hsync_s1;
      vsync_s1_q <= vsync_s1;
    end
  end

  assign hs_rise = hsync_s1 & ~hsync_s1_q;
  assign vs_rise = vsync_s1 & ~vsync_s1_q;

  // Half-pixel phase register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HALF_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Phase decode: DE low always lands in HALF_A, so every DE rise realigns the pairing
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    pix_en    = 1'b0;
    err_now   = 1'b0;
    case (state)
      HALF_A: begin
        if (de_s1) begin
          latch_en  = 1'b1;
          state_nxt = HALF_B;
        end
      end
      HALF_B: begin
        state_nxt = HALF_A;
        if (de_s1) begin
          pix_en = 1'b1;
        end else begin
          err_now = 1'b1;
        end
      end
      default: state_nxt = HALF_A;
    endcase
  end

  // Pixel output stage: first word is {R, G[7:4]}, second is {G[3:0], B}; syncs ride alongside
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_word   <= '0;
      o_r         <= '0;
      o_g         <= '0;
      o_b         <= '0;
      o_pix_valid <= 1'b0;
      o_err_phase <= 1'b0;
      o_hsync     <= 1'b0;
      o_vsync     <= 1'b0;
    end else begin
      if (latch_en) begin
        half_word <= data_s1;
      end
      if (pix_en) begin
        o_r <= half_word[11:4];
        o_g <= {half_word[3:0], data_s1[11:8]};
        o_b <= data_s1[7:0];
      end
      o_pix_valid <= pix_en;
      o_err_phase <= err_now;
      o_hsync     <= hsync_s1;
      o_vsync     <= vsync_s1;
    end
  end

  assign de_pix = de_cnt[WORD_W-1:1];

  // Line close-out values; the frame update reads these so a coincident hsync is counted first
  always_comb begin
    h_line_nxt = h_line;
    h_act_nxt  = h_act_line;
    v_cnt_nxt  = v_cnt;
    v_act_nxt  = v_act_cnt;
    if (hs_rise) begin
      h_line_nxt = word_cnt[WORD_W-1:1];
      if (de_pix != '0) begin
        h_act_nxt = de_pix;
      end
      v_cnt_nxt = inc_cnt(v_cnt);
      if (de_cnt != '0) begin
        v_act_nxt = inc_cnt(v_act_cnt);
      end
    end
  end

  // Per-line word/DE counters and per-frame line counters; the hsync-rise word opens the new line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt   <= '0;
      de_cnt     <= '0;
      h_line     <= '0;
      h_act_line <= '0;
      v_cnt      <= '0;
      v_act_cnt  <= '0;
    end else begin
      if (hs_rise) begin
        word_cnt <= WORD_W'(1);
        de_cnt   <= WORD_W'(de_s1);
      end else begin
        word_cnt <= inc_word(word_cnt);
        if (de_s1) begin
          de_cnt <= inc_word(de_cnt);
        end
      end
      h_line     <= h_line_nxt;
      h_act_line <= h_act_nxt;
      if (vs_rise) begin
        v_cnt     <= '0;
        v_act_cnt <= '0;
      end else begin
        v_cnt     <= v_cnt_nxt;
        v_act_cnt <= v_act_nxt;
      end
    end
  end

  // Stability tracking. The first publish after reset is partial and never
  // counts; the first full frame has nothing trustworthy to compare against,
  // so it starts a run of one unless it saw a phase error.
  always_comb begin
    tuple_match = (h_line_nxt == o_h_total) && (h_act_nxt == o_h_active) &&
                  (v_cnt_nxt == o_v_total) && (v_act_nxt == o_v_active);
    frame_err   = err_seen | err_now;
    stable_nxt  = stable;
    case (pub_seen)
      2'd0: stable_nxt = 4'd0;
      2'd1: stable_nxt = frame_err ? 4'd0 : 4'd1;
      default: begin
        if (tuple_match && !frame_err) begin
          stable_nxt = (stable == STABLE_MAX) ? STABLE_MAX : stable + 4'd1;
        end else begin
          stable_nxt = 4'd0;
        end
      end
    endcase
  end

  // Frame publication on vsync rise: all four measurements, stable count and lock move together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_h_total  <= '0;
      o_h_active <= '0;
      o_v_total  <= '0;
      o_v_active <= '0;
      o_locked   <= 1'b0;
      stable     <= 4'd0;
      pub_seen   <= 2'd0;
      err_seen   <= 1'b0;
    end else if (vs_rise) begin
      o_h_total  <= h_line_nxt;
      o_h_active <= h_act_nxt;
      o_v_total  <= v_cnt_nxt;
      o_v_active <= v_act_nxt;
      stable     <= stable_nxt;
      o_locked   <= (stable_nxt >= LOCK_THR);
      if (pub_seen != 2'd2) begin
        pub_seen <= pub_seen + 2'd1;
      end
      err_seen   <= 1'b0;
    end else if (err_now) begin
      err_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adv_ddr_capture.sv
// tb_adv_ddr_capture: directed frames into adv_ddr_capture, pixel scoreboard plus timing/lock checks.
// Latency: expects pixels and syncs 2 clk after the completing input word.
// Backpressure: none; stimulus streams one word per clk.
module tb_adv_ddr_capture;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        de    = 1'b0;
  logic        hs    = 1'b0;
  logic        vs    = 1'b0;
  logic [11:0] data  = '0;

  logic [7:0]  o_r, o_g, o_b;
  logic        o_pix_valid, o_hsync, o_vsync, o_locked, o_err_phase;
  logic [11:0] o_h_total, o_h_active, o_v_total, o_v_active;

  logic [7:0]  r8, g8, b8;
  logic        pv8, hs8, vs8, lk8, ep8;
  logic [7:0]  ht8, ha8, vt8, va8;

  adv_ddr_capture #(.CNT_W(12), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .i_de(de), .i_hsync(hs), .i_vsync(vs), .i_data(data),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_pix_valid(o_pix_valid),
    .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_h_total(o_h_total), .o_h_active(o_h_active),
    .o_v_total(o_v_total), .o_v_active(o_v_active),
    .o_locked(o_locked), .o_err_phase(o_err_phase)
  );

  adv_ddr_capture #(.CNT_W(8), .LOCK_FRAMES(2)) dut8 (
    .clk(clk), .reset(reset), .i_de(de), .i_hsync(hs), .i_vsync(vs), .i_data(data),
    .o_r(r8), .o_g(g8), .o_b(b8), .o_pix_valid(pv8),
    .o_hsync(hs8), .o_vsync(vs8),
    .o_h_total(ht8), .o_h_active(ha8),
    .o_v_total(vt8), .o_v_active(va8),
    .o_locked(lk8), .o_err_phase(ep8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-clock reference delay for the sync outputs
  logic hs_d1, hs_d2, vs_d1, vs_d2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_d1 <= 1'b0; hs_d2 <= 1'b0; vs_d1 <= 1'b0; vs_d2 <= 1'b0;
    end else begin
      hs_d1 <= hs; hs_d2 <= hs_d1; vs_d1 <= vs; vs_d2 <= vs_d1;
    end
  end

  typedef struct {
    logic [23:0] pix;
    int          t;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   npix = 0;
  int   nerr = 0;
  int   n_push = 0;
  int   n_err_exp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every pixel strobe, checks error pulses and sync delay
  initial begin
    exp_t e;
    logic err_prev;
    logic p_hs;
    logic p_vs;
    err_prev = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        err_prev = 1'b0; p_hs = 1'b0; p_vs = 1'b0;
      end else begin
        if (o_pix_valid) begin
          npix++;
          if (q.size() == 0) begin
            chk("pix_queue_depth", 32'(q.size()), 32'd1);
          end else begin
            e = q.pop_front();
            chk("pix_rgb", 32'({o_r, o_g, o_b}), 32'(e.pix));
            chk("pix_latency", 32'(cyc), 32'(e.t));
          end
        end
        if (o_err_phase) begin
          nerr++;
          chk("err_pulse_width", 32'(err_prev), 32'd0);
        end
        err_prev = o_err_phase;
        if (hs_d2 != p_hs) begin
          chk("o_hsync_delay", 32'(o_hsync), 32'(hs_d2));
          p_hs = hs_d2;
        end
        if (vs_d2 != p_vs) begin
          chk("o_vsync_delay", 32'(o_vsync), 32'(vs_d2));
          p_vs = vs_d2;
        end
      end
    end
  end

  task automatic put(input logic d, input logic h, input logic v, input logic [11:0] w);
    @(posedge clk);
    #1;
    de = d; hs = h; vs = v; data = w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    de = 1'b0; hs = 1'b0; vs = 1'b0; data = '0;
    #1;
    chk("reset_pix_outputs", 32'({o_r, o_g, o_b, o_pix_valid, o_hsync, o_vsync, o_locked, o_err_phase}), 32'd0);
    chk("reset_h_meas", 32'({o_h_total, o_h_active}), 32'd0);
    chk("reset_v_meas", 32'({o_v_total, o_v_active}), 32'd0);
    q.delete();
    n_push = npix;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One frame: vsync high for line 0, hsync high for words 0..3 of every line,
  // DE from word 4 on the last na lines. Line err_line carries one extra DE word.
  // The checks at line 0 word 4 look at what the vsync rise just published.
  task automatic run_frame(input int hw, input int dw, input int nl, input int na,
                           input bit vary, input int err_line, input int abort_line,
                           input bit chk_tup, input int eh, input int ea, input int ev, input int eva,
                           input bit elock, input int e8h, input int e8a);
    logic [11:0] first;
    logic [11:0] w;
    bit          have;
    exp_t        ne;
    first = '0;
    have  = 1'b0;
    for (int l = 0; l < nl; l++) begin
      if (l == err_line) n_err_exp++;
      for (int x = 0; x < hw; x++) begin
        int   nde;
        logic d;
        nde = (l == err_line) ? dw + 1 : dw;
        d   = (l >= nl - na) && (x >= 4) && (x < 4 + nde);
        if (vary) w = 12'((x * 37 + l * 5) ^ (x << 6));
        else      w = have ? 12'h2CD : 12'hAB1;
        put(d, x < 4, l == 0, w);
        if (d) begin
          if (!have) begin
            first = w;
            have  = 1'b1;
          end else begin
            ne.pix = vary ? {first, w} : 24'hAB12CD;
            ne.t   = cyc + 2;
            q.push_back(ne);
            n_push++;
            have = 1'b0;
          end
        end else begin
          have = 1'b0;
        end
        if (l == 0 && x == 4) begin
          chk("o_locked", 32'(o_locked), 32'(elock));
          chk("pix_count", 32'(npix), 32'(n_push));
          chk("err_count", 32'(nerr), 32'(n_err_exp));
          if (chk_tup) begin
            chk("o_h_total", 32'(o_h_total), 32'(eh));
            chk("o_h_active", 32'(o_h_active), 32'(ea));
            chk("o_v_total", 32'(o_v_total), 32'(ev));
            chk("o_v_active", 32'(o_v_active), 32'(eva));
          end
          if (e8h >= 0) begin
            chk("w8_h_total", 32'(ht8), 32'(e8h));
            chk("w8_h_active", 32'(ha8), 32'(e8a));
          end
        end
        if (l == abort_line && x == 10) begin
          do_reset();
          return;
        end
      end
    end
  endtask

  initial begin
    #2;
    do_reset();
    // Small frames: 40 words/line, 32 DE words, 10 lines, 8 active, fixed AB1/2CD words
    run_frame(40, 32, 10, 8, 0, -1, -1, 0,  0,  0,  0, 0, 0, -1, 0); // partial publish
    run_frame(40, 32, 10, 8, 0, -1, -1, 1, 20, 16, 10, 8, 0, -1, 0); // first full frame
    run_frame(40, 32, 10, 8, 0, -1, -1, 1, 20, 16, 10, 8, 1, -1, 0); // locks on 3rd vsync
    run_frame(40, 32, 10, 8, 0, -1, -1, 1, 20, 16, 10, 8, 1, -1, 0);
    run_frame(40, 32, 10, 8, 0,  9, -1, 1, 20, 16, 10, 8, 1, -1, 0); // 33-word DE line
    run_frame(40, 32, 10, 8, 0, -1, -1, 1, 20, 16, 10, 8, 0, -1, 0); // lock lost on error
    run_frame(40, 32, 10, 8, 0, -1,  5, 1, 20, 16, 10, 8, 0, -1, 0); // reset during DE
    run_frame(40, 32, 10, 8, 0, -1, -1, 0,  0,  0,  0, 0, 0, -1, 0);
    run_frame(40, 32, 10, 8, 0, -1, -1, 1, 20, 16, 10, 8, 0, -1, 0); // full, not yet locked
    run_frame(40, 32, 10, 8, 0, -1, -1, 1, 20, 16, 10, 8, 1, -1, 0);
    // 720p50 line timing (shortened frames), then 720p60 line length
    run_frame(3960, 2560, 2, 1, 1, -1, -1, 1,   20,   16, 10, 8, 1, -1, 0);
    run_frame(3960, 2560, 2, 1, 1, -1, -1, 1, 1980, 1280,  2, 1, 0, -1, 0);
    run_frame(3960, 2560, 2, 1, 1, -1, -1, 1, 1980, 1280,  2, 1, 0, -1, 0);
    run_frame(3300, 2560, 2, 1, 1, -1, -1, 1, 1980, 1280,  2, 1, 1, -1, 0);
    run_frame(3300, 2560, 2, 1, 1, -1, -1, 1, 1650, 1280,  2, 1, 0, -1, 0);
    run_frame(3300, 2560, 2, 1, 1, -1, -1, 1, 1650, 1280,  2, 1, 0, -1, 0);
    // 300-pixel lines: 12-bit instance reads 300, 8-bit instance pins at 255
    run_frame(600, 40, 2, 1, 1, -1, -1, 1, 1650, 1280, 2, 1, 1,  -1,  0);
    run_frame(600, 40, 2, 1, 1, -1, -1, 1,  300,   20, 2, 1, 0, 255, 20);
    run_frame(40,  32, 2, 0, 0, -1, -1, 1,  300,   20, 2, 1, 0, 255, 20);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
